// File: rtl/mean.sv
// Per-frame R/G/B mean accumulator for the white-balance path.
// Means publish on the cycle after the last beat of each frame.
module mean (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [1:0] color_i,
    input  logic [7:0] value_i,
    input  logic       last_i,
    input  logic [4:0] size_i,
    output logic [7:0] r_mean_o,
    output logic [7:0] g_mean_o,
    output logic [7:0] b_mean_o,
    output logic       valid_o,
    output logic [1:0] color_o,
    output logic       last_o
);

    logic [29:0] sum_r_q, sum_r_d;
    logic [29:0] sum_g_q, sum_g_d;
    logic [29:0] sum_b_q, sum_b_d;
    logic [29:0] add_r, add_g, add_b;
    logic [7:0]  r_mean_q, r_mean_d;
    logic [7:0]  g_mean_q, g_mean_d;
    logic [7:0]  b_mean_q, b_mean_d;
    logic        valid_q, last_q;
    logic [1:0]  color_q;
    logic [4:0]  shift_rb, shift_g;
    logic        end_frame;

    function automatic logic [7:0] sat(input logic [29:0] x);
        return (x > 30'd255) ? 8'hFF : x[7:0];
    endfunction

    assign end_frame = valid_i & last_i;

    always_comb begin
        add_r = sum_r_q + ((valid_i && color_i == 2'd0) ? {22'd0, value_i} : 30'd0);
        add_g = sum_g_q + ((valid_i && color_i == 2'd1) ? {22'd0, value_i} : 30'd0);
        add_b = sum_b_q + ((valid_i && color_i == 2'd2) ? {22'd0, value_i} : 30'd0);
        shift_rb = (size_i > 5'd20) ? 5'd20 : size_i;
        shift_g  = shift_rb + 5'd1;
        sum_r_d  = add_r;
        sum_g_d  = add_g;
        sum_b_d  = add_b;
        r_mean_d = r_mean_q;
        g_mean_d = g_mean_q;
        b_mean_d = b_mean_q;
        // Last beat: fold its sample in, publish, and start the next frame clean.
        if (end_frame) begin
            r_mean_d = sat(add_r >> shift_rb);
            g_mean_d = sat(add_g >> shift_g);
            b_mean_d = sat(add_b >> shift_rb);
            sum_r_d  = 30'd0;
            sum_g_d  = 30'd0;
            sum_b_d  = 30'd0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sum_r_q  <= 30'd0;
            sum_g_q  <= 30'd0;
            sum_b_q  <= 30'd0;
            r_mean_q <= 8'd0;
            g_mean_q <= 8'd0;
            b_mean_q <= 8'd0;
            valid_q  <= 1'b0;
            color_q  <= 2'd0;
            last_q   <= 1'b0;
        end else begin
            sum_r_q  <= sum_r_d;
            sum_g_q  <= sum_g_d;
            sum_b_q  <= sum_b_d;
            r_mean_q <= r_mean_d;
            g_mean_q <= g_mean_d;
            b_mean_q <= b_mean_d;
            valid_q  <= valid_i;
            color_q  <= color_i;
            last_q   <= end_frame;
        end
    end

    assign r_mean_o = r_mean_q;
    assign g_mean_o = g_mean_q;
    assign b_mean_o = b_mean_q;
    assign valid_o  = valid_q;
    assign color_o  = color_q;
    assign last_o   = last_q;

endmodule

// File: tb/tb_mean.sv
// Self-checking bench for mean: reference model feeds a scoreboard
// that is drained whenever last_o pulses.
module tb_mean;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic [1:0] color_i;
    logic [7:0] value_i;
    logic       last_i;
    logic [4:0] size_i;
    logic [7:0] r_mean_o, g_mean_o, b_mean_o;
    logic       valid_o;
    logic [1:0] color_o;
    logic       last_o;

    typedef struct {
        int r;
        int g;
        int b;
    } means_t;

    means_t sb[$];
    means_t held = '{0, 0, 0};
    int checks = 0;
    int errors = 0;
    int sum_r = 0, sum_g = 0, sum_b = 0;
    logic       e_v = 1'b0;
    logic       e_l = 1'b0;
    logic [1:0] e_c = 2'd0;

    mean dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .color_i  (color_i),
        .value_i  (value_i),
        .last_i   (last_i),
        .size_i   (size_i),
        .r_mean_o (r_mean_o),
        .g_mean_o (g_mean_o),
        .b_mean_o (b_mean_o),
        .valid_o  (valid_o),
        .color_o  (color_o),
        .last_o   (last_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic beat(input logic v, input logic [1:0] c,
                        input int val, input logic l);
        int s;
        valid_i = v;
        color_i = c;
        value_i = val[7:0];
        last_i  = l;
        if (v) begin
            case (c)
                2'd0: sum_r += val;
                2'd1: sum_g += val;
                2'd2: sum_b += val;
                default: ;
            endcase
            if (l) begin
                s = (size_i > 5'd20) ? 20 : int'(size_i);
                sb.push_back('{sat(sum_r >> s), sat(sum_g >> (s + 1)),
                               sat(sum_b >> s)});
                sum_r = 0;
                sum_g = 0;
                sum_b = 0;
            end
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic frame(input bit gaps, input bit flat, input int fv);
        int vals[8] = '{10, 20, 30, 40, 50, 60, 100, 200};
        logic [1:0] cols[8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                beat(1'b0, 2'(i % 4), 0, 1'b1);
                beat(1'b1, 2'd3, 255, 1'b0);
            end
            beat(1'b1, cols[i], flat ? fv : vals[i], i == 7);
        end
    endtask

    task automatic expect_means(input string tag, input int r,
                                input int g, input int b);
        @(negedge clk);
        check({tag, "_last"}, int'(last_o), 1);
        check({tag, "_r"}, int'(r_mean_o), r);
        check({tag, "_g"}, int'(g_mean_o), g);
        check({tag, "_b"}, int'(b_mean_o), b);
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            e_v = 1'b0;
            e_c = 2'd0;
            e_l = 1'b0;
        end else begin
            e_v = valid_i;
            e_c = color_i;
            e_l = valid_i & last_i;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("rst_valid", int'(valid_o), 0);
            check("rst_last", int'(last_o), 0);
            check("rst_r", int'(r_mean_o), 0);
            held = '{0, 0, 0};
            sb.delete();
        end else begin
            check("valid_o", int'(valid_o), int'(e_v));
            check("color_o", int'(color_o), int'(e_c));
            check("last_o", int'(last_o), int'(e_l));
            if (last_o) begin
                check("sb_size", sb.size(), 1);
                if (sb.size() > 0) held = sb.pop_front();
            end
            check("sb_r", int'(r_mean_o), held.r);
            check("sb_g", int'(g_mean_o), held.g);
            check("sb_b", int'(b_mean_o), held.b);
        end
    end

    initial begin
        rst_n   = 1'b1;
        valid_i = 1'b0;
        color_i = 2'd0;
        value_i = 8'd0;
        last_i  = 1'b0;
        size_i  = 5'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_g", int'(g_mean_o), 0);
        check("reset_b", int'(b_mean_o), 0);
        check("reset_color", int'(color_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b0;

        frame(1'b0, 1'b0, 0);
        expect_means("basic", 15, 45, 150);

        frame(1'b1, 1'b0, 0);
        expect_means("gaps", 15, 45, 150);

        size_i = 5'd0;
        beat(1'b1, 2'd0, 3, 1'b0);
        beat(1'b1, 2'd1, 2, 1'b0);
        beat(1'b1, 2'd1, 3, 1'b0);
        beat(1'b1, 2'd2, 1, 1'b1);
        expect_means("trunc", 3, 2, 1);

        beat(1'b1, 2'd0, 200, 1'b0);
        beat(1'b1, 2'd0, 200, 1'b1);
        expect_means("satur", 255, 0, 0);

        size_i = 5'd1;
        frame(1'b0, 1'b0, 0);
        expect_means("b2b1", 15, 45, 150);
        frame(1'b0, 1'b1, 8);
        expect_means("b2b2", 8, 8, 8);

        beat(1'b0, 2'd0, 0, 1'b0);
        beat(1'b1, 2'd0, 10, 1'b0);
        beat(1'b1, 2'd1, 30, 1'b0);
        beat(1'b1, 2'd2, 100, 1'b0);
        rst_n = 1'b1;
        #1;
        check("async_r", int'(r_mean_o), 0);
        check("async_g", int'(g_mean_o), 0);
        check("async_b", int'(b_mean_o), 0);
        check("async_valid", int'(valid_o), 0);
        check("async_color", int'(color_o), 0);
        sum_r = 0;
        sum_g = 0;
        sum_b = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;

        frame(1'b0, 1'b0, 0);
        expect_means("post_rst", 15, 45, 150);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
